// File: rtl/cpu_data_ram.sv
//==============================================================================
// Module   : cpu_data_ram
// Purpose  : CPU data memory with a req/ack host load/inspect port.
//            Define CPU_RAM_PARITY_EN to add per-word even parity and par_err.
// Revision : 1.0
//==============================================================================
`default_nettype none

module cpu_data_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ram_write,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram_busy,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  par_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef CPU_RAM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOST = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [MW-1:0]           mem [DEPTH];
  logic                    hwe_q;
  logic [ADDR_WIDTH-1:0]   haddr_q;
  logic [DATA_WIDTH-1:0]   hwdata_q;
  logic                    pend_valid_q;
  logic [ADDR_WIDTH-1:0]   pend_addr_q;
  logic [DATA_WIDTH-1:0]   pend_data_q;
  logic [DATA_WIDTH-1:0]   ram_rdata_q;
  logic [DATA_WIDTH-1:0]   host_rdata_q;

  logic                    in_host;
  logic                    cpu_fwd;
  logic                    host_fwd;
  logic [MW-1:0]           cpu_word;
  logic [MW-1:0]           host_word;

  function automatic logic [MW-1:0] enc(input logic [DATA_WIDTH-1:0] d);
`ifdef CPU_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign in_host   = (state_q == S_HOST);
  assign cpu_word  = mem[ram_addr];
  assign host_word = mem[haddr_q];
  assign cpu_fwd   = pend_valid_q && (pend_addr_q == ram_addr);
  assign host_fwd  = pend_valid_q && (pend_addr_q == haddr_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (host_req) state_d = S_HOST;
      S_HOST:  state_d = S_ACK;
      S_ACK:   if (!host_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hwe_q        <= 1'b0;
      haddr_q      <= '0;
      hwdata_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      ram_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && host_req) begin
        hwe_q    <= host_we;
        haddr_q  <= host_addr;
        hwdata_q <= host_wdata;
      end
      if (in_host) begin
        // CPU writes that land while the host owns the array are deferred one cycle.
        if (ram_write) begin
          pend_valid_q <= 1'b1;
          pend_addr_q  <= ram_addr;
          pend_data_q  <= ram_wdata;
        end
        if (!hwe_q) host_rdata_q <= host_fwd ? pend_data_q : host_word[DATA_WIDTH-1:0];
      end else begin
        pend_valid_q <= 1'b0;
        ram_rdata_q  <= cpu_fwd ? pend_data_q : cpu_word[DATA_WIDTH-1:0];
      end
    end
  end

  // Pending commit precedes the new CPU write so the later write wins on a shared address.
  always_ff @(posedge clk) begin
    if (in_host) begin
      if (hwe_q) mem[haddr_q] <= enc(hwdata_q);
    end else begin
      if (pend_valid_q) mem[pend_addr_q] <= enc(pend_data_q);
      if (ram_write)    mem[ram_addr]    <= enc(ram_wdata);
    end
  end

`ifdef CPU_RAM_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if ((!in_host && !cpu_fwd && (^cpu_word)) ||
                 (in_host && !hwe_q && !host_fwd && (^host_word))) begin
      par_err_q <= 1'b1;
    end
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign ram_rdata  = ram_rdata_q;
  assign host_rdata = host_rdata_q;
  assign ram_busy   = in_host;
  assign host_ack   = (state_q == S_ACK);

endmodule

`default_nettype wire

// File: tb/tb_cpu_data_ram.sv
//==============================================================================
// Module   : tb_cpu_data_ram
// Purpose  : Self-checking bench for cpu_data_ram against a logical memory model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_cpu_data_ram;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_write = 1'b0;
  logic [AW-1:0] ram_addr = '0;
  logic [DW-1:0] ram_wdata = '0;
  logic [DW-1:0] ram_rdata;
  logic          ram_busy;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          par_err;

  always #5 clk = ~clk;

  cpu_data_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .par_err(par_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Logical memory: every CPU write takes effect at its own edge, host writes
  // are ordered before a CPU write of the same edge.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            kn [DEPTH];
  int            m_phase = 0;          // 0 idle, 1 host owns array, 2 acknowledging
  logic          l_we = 1'b0;
  logic [AW-1:0] l_a = '0;
  logic [DW-1:0] l_d = '0;
  logic [DW-1:0] exp_rd = '0;
  bit            exp_rd_kn = 1'b1;
  logic [DW-1:0] exp_hrd = '0;
  bit            exp_hrd_kn = 1'b0;
  logic          exp_par = 1'b0;

  task automatic step(input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    ram_write = cw; ram_addr = ca; ram_wdata = cd;
    @(posedge clk);
    if (m_phase == 1) begin
      if (l_we) begin ref_mem[l_a] = l_d; kn[l_a] = 1'b1; end
      else begin exp_hrd = ref_mem[l_a]; exp_hrd_kn = kn[l_a]; end
    end else begin
      exp_rd = ref_mem[ca]; exp_rd_kn = kn[ca];
    end
    if (cw) begin ref_mem[ca] = cd; kn[ca] = 1'b1; end
    case (m_phase)
      0: if (host_req) begin m_phase = 1; l_we = host_we; l_a = host_addr; l_d = host_wdata; end
      1: m_phase = 2;
      default: if (!host_req) m_phase = 0;
    endcase
    #1;
  endtask

  task automatic host_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ram_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", ram_rdata); end
    n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", host_ack); end
    n_cmp++; if (host_rdata !== '0) begin n_bad++; $display("FAIL reset_hrdata: got %h want 0", host_rdata); end
    n_cmp++; if (ram_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", ram_busy); end
    n_cmp++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL reset_par: got %b want 0", par_err); end
    @(negedge clk);
    rst_n = 1'b1;
    m_phase = 0; exp_rd = '0; exp_rd_kn = 1'b1;
  endtask

  task automatic test_host_basic();
    int lat;
    host_start(1'b1, 8'h05, 16'h1234);
    step(1'b0, 8'h00, 16'h0);
    lat = 1;
    n_cmp++; if (ram_busy !== 1'b1 || host_ack !== 1'b0) begin
      n_bad++; $display("FAIL host_busy_phase: busy=%b ack=%b want busy=1 ack=0", ram_busy, host_ack);
    end
    while (!host_ack && lat < 6) begin step(1'b0, 8'h00, 16'h0); lat++; end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL host_ack_latency: got %0d want 2", lat); end
    host_req = 1'b0;
    step(1'b0, 8'h00, 16'h0);
    n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL host_ack_drop: got %b want 0", host_ack); end
    step(1'b0, 8'h00, 16'h0);
    host_start(1'b0, 8'h05, 16'h0);
    lat = 0;
    while (!host_ack && lat < 6) begin step(1'b0, 8'h00, 16'h0); lat++; end
    n_cmp++; if (host_rdata !== 16'h1234 || host_ack !== 1'b1) begin
      n_bad++; $display("FAIL host_read_05: got %h ack=%b want 1234 ack=1", host_rdata, host_ack);
    end
    host_req = 1'b0;
    repeat (2) step(1'b0, 8'h00, 16'h0);
  endtask

  task automatic test_preload();
    for (int a = 0; a < DEPTH; a++) begin
      host_start(1'b1, AW'(a), DW'($urandom));
      repeat (2) step(1'b0, 8'h00, 16'h0);
      n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL preload_ack a=%0d: got %b want 1", a, host_ack); end
      host_req = 1'b0;
      repeat (2) step(1'b0, 8'h00, 16'h0);
    end
  endtask

  task automatic test_cpu_rw();
    logic [DW-1:0] old;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    old = ref_mem[8'h10];
    step(1'b1, 8'h10, 16'hBEEF);
    n_cmp++; if (ram_rdata !== old) begin n_bad++; $display("FAIL rbw_old: got %h want %h", ram_rdata, old); end
    step(1'b0, 8'h10, 16'h0);
    n_cmp++; if (ram_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL cpu_read_10: got %h want beef", ram_rdata); end
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom); d = DW'($urandom);
      step(1'b1, a, d);
      step(1'b0, a, 16'h0);
      n_cmp++; if (ram_rdata !== d) begin n_bad++; $display("FAIL cpu_wr_rd a=%h: got %h want %h", a, ram_rdata, d); end
    end
  endtask

  task automatic test_pending_forward();
    logic [DW-1:0] old20;
    logic [DW-1:0] v21;
    old20 = ref_mem[8'h20];
    v21 = ref_mem[8'h21];
    host_start(1'b0, 8'h21, 16'h0);
    step(1'b0, 8'h20, 16'h0);
    n_cmp++; if (ram_busy !== 1'b1) begin n_bad++; $display("FAIL pend_busy: got %b want 1", ram_busy); end
    step(1'b1, 8'h20, 16'h00AA);
    n_cmp++; if (ram_rdata !== old20) begin n_bad++; $display("FAIL host_hold_rdata: got %h want %h", ram_rdata, old20); end
    n_cmp++; if (host_ack !== 1'b1 || host_rdata !== v21) begin
      n_bad++; $display("FAIL pend_host_read: ack=%b got %h want %h", host_ack, host_rdata, v21);
    end
    host_req = 1'b0;
    step(1'b0, 8'h20, 16'h0);
    n_cmp++; if (ram_rdata !== 16'h00AA) begin n_bad++; $display("FAIL pend_forward: got %h want 00aa", ram_rdata); end
    step(1'b0, 8'h20, 16'h0);
    n_cmp++; if (ram_rdata !== 16'h00AA) begin n_bad++; $display("FAIL pend_commit: got %h want 00aa", ram_rdata); end
    host_start(1'b0, 8'h20, 16'h0);
    repeat (2) step(1'b0, 8'h00, 16'h0);
    n_cmp++; if (host_rdata !== 16'h00AA) begin n_bad++; $display("FAIL pend_array_20: got %h want 00aa", host_rdata); end
    host_req = 1'b0;
    repeat (2) step(1'b0, 8'h00, 16'h0);
  endtask

  task automatic test_collision();
    host_start(1'b1, 8'h30, 16'h1111);
    step(1'b0, 8'h00, 16'h0);
    step(1'b1, 8'h30, 16'h2222);
    host_req = 1'b0;
    step(1'b0, 8'h30, 16'h0);
    n_cmp++; if (ram_rdata !== 16'h2222) begin n_bad++; $display("FAIL coll_fwd: got %h want 2222", ram_rdata); end
    step(1'b0, 8'h30, 16'h0);
    n_cmp++; if (ram_rdata !== 16'h2222) begin n_bad++; $display("FAIL coll_cpu: got %h want 2222", ram_rdata); end
    host_start(1'b0, 8'h30, 16'h0);
    repeat (2) step(1'b0, 8'h00, 16'h0);
    n_cmp++; if (host_rdata !== 16'h2222) begin n_bad++; $display("FAIL coll_host: got %h want 2222", host_rdata); end
    host_req = 1'b0;
    repeat (2) step(1'b0, 8'h00, 16'h0);
  endtask

  task automatic test_random();
    int wait_c = 0;
    int idle_c = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!host_req && m_phase == 0 && idle_c > 1 && $urandom_range(0, 3) == 0) begin
        host_start(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        wait_c = 0;
      end
      step(1'($urandom_range(0, 2) == 0), AW'($urandom), DW'($urandom));
      idle_c = (m_phase == 0 && !host_req) ? idle_c + 1 : 0;
      n_cmp++; if (ram_busy !== 1'(m_phase == 1)) begin
        n_bad++; $display("FAIL rnd_busy i=%0d: got %b want %b", i, ram_busy, m_phase == 1);
      end
      n_cmp++; if (host_ack !== 1'(m_phase == 2)) begin
        n_bad++; $display("FAIL rnd_ack i=%0d: got %b want %b", i, host_ack, m_phase == 2);
      end
      if (exp_rd_kn) begin
        n_cmp++; if (ram_rdata !== exp_rd) begin
          n_bad++; $display("FAIL rnd_rdata i=%0d: got %h want %h", i, ram_rdata, exp_rd);
        end
      end
      if (m_phase == 2 && !l_we && exp_hrd_kn) begin
        n_cmp++; if (host_rdata !== exp_hrd) begin
          n_bad++; $display("FAIL rnd_hrdata i=%0d: got %h want %h", i, host_rdata, exp_hrd);
        end
      end
      n_cmp++; if (par_err !== exp_par) begin n_bad++; $display("FAIL rnd_par i=%0d: got %b want %b", i, par_err, exp_par); end
      if (host_req) begin
        wait_c++;
        if (host_ack) host_req = 1'b0;
        else if (wait_c > 4) begin
          n_cmp++; n_bad++; $display("FAIL rnd_ack_timeout i=%0d: no ack after %0d cycles", i, wait_c);
          host_req = 1'b0;
        end
      end
    end
    host_req = 1'b0;
    repeat (3) step(1'b0, 8'h00, 16'h0);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] old50;
    old50 = ref_mem[8'h50];
    host_start(1'b0, 8'h60, 16'h0);
    step(1'b0, 8'h50, 16'h0);
    step(1'b1, 8'h50, 16'h5A5A);
    n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL mid_ack_before: got %b want 1", host_ack); end
    ram_write = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL mid_ack_async: got %b want 0", host_ack); end
    n_cmp++; if (ram_rdata !== '0) begin n_bad++; $display("FAIL mid_rdata_async: got %h want 0", ram_rdata); end
    ref_mem[8'h50] = old50;
    m_phase = 0; exp_rd = '0;
    host_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h50, 16'h0);
    n_cmp++; if (ram_rdata !== old50) begin n_bad++; $display("FAIL mid_pend_dropped: got %h want %h", ram_rdata, old50); end
    n_cmp++; if (ram_busy !== 1'b0 || host_ack !== 1'b0) begin
      n_bad++; $display("FAIL mid_idle: busy=%b ack=%b want 0 0", ram_busy, host_ack);
    end
    host_start(1'b0, 8'h50, 16'h0);
    repeat (2) step(1'b0, 8'h00, 16'h0);
    n_cmp++; if (host_ack !== 1'b1 || host_rdata !== old50) begin
      n_bad++; $display("FAIL mid_host_after: ack=%b got %h want %h", host_ack, host_rdata, old50);
    end
    host_req = 1'b0;
    repeat (2) step(1'b0, 8'h00, 16'h0);
  endtask

`ifdef CPU_RAM_PARITY_EN
  task automatic test_parity();
    step(1'b1, 8'h40, 16'h0F0F);
    step(1'b0, 8'h00, 16'h0);
    dut.mem[8'h40][0] = ~dut.mem[8'h40][0];
    ref_mem[8'h40] = ref_mem[8'h40] ^ 16'h0001;
    exp_par = 1'b1;
    step(1'b0, 8'h40, 16'h0);
    n_cmp++; if (par_err !== 1'b1) begin n_bad++; $display("FAIL par_set: got %b want 1", par_err); end
    repeat (3) step(1'b0, 8'h00, 16'h0);
    n_cmp++; if (par_err !== 1'b1) begin n_bad++; $display("FAIL par_sticky: got %b want 1", par_err); end
    #2 rst_n = 1'b0;
    #1;
    exp_par = 1'b0;
    n_cmp++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL par_clear: got %b want 0", par_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_host_basic();
    test_preload();
    test_cpu_rw();
    test_pending_forward();
    test_collision();
    test_random();
    test_reset_mid();
`ifdef CPU_RAM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
